// File: rtl/register_file_2r1w_if.sv
// Bus bundle for the 2-read/1-write register file: write port, two read
// ports and the clear-sweep control/status.
interface register_file_2r1w_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              clr;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en_a;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [DATA_W-1:0] rd_data_a;
    logic              rd_en_b;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_b;
    logic              busy;

    modport master (
        output clr, wr_en, wr_addr, wr_data,
        output rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
        input  rd_data_a, rd_data_b, busy
    );

    modport slave (
        input  clr, wr_en, wr_addr, wr_data,
        input  rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
        output rd_data_a, rd_data_b, busy
    );
endinterface

// File: rtl/register_file_2r1w.sv
// General-purpose register file with one write port and two registered read
// ports. Reads forward a same-cycle write (write-first). The storage array is
// not reset; a sweep FSM zeroes every entry after reset and on a clr pulse,
// and busy is high while it runs. ZERO_REG=1 hard-wires entry 0 to zero.
module register_file_2r1w #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 0
) (
    input logic                 clk,
    input logic                 reset_n,
    register_file_2r1w_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] clr_ptr_q;
    logic [ADDR_W-1:0] clr_ptr_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              clearing;
    logic              wr_acc;
    logic [DATA_W-1:0] rd_next_a;
    logic [DATA_W-1:0] rd_next_b;
    logic [DATA_W-1:0] rd_data_a_p1;
    logic [DATA_W-1:0] rd_data_b_p1;

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    // Read-port mux: sweep and zero register force 0, an accepted write to
    // the same address wins over the stored value.
    function automatic logic [DATA_W-1:0] read_sel(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              in_clear,
        input logic              fwd_en,
        input logic [ADDR_W-1:0] fwd_addr,
        input logic [DATA_W-1:0] fwd_data
    );
        if (in_clear || is_zero_reg(addr)) return '0;
        if (fwd_en && (fwd_addr == addr))  return fwd_data;
        return stored;
    endfunction

    assign clearing     = (state_q == CLEAR);
    assign wr_acc       = !clearing && bus.wr_en && !bus.clr && !is_zero_reg(bus.wr_addr);
    assign bus.busy     = clearing;
    assign bus.rd_data_a = rd_data_a_p1;
    assign bus.rd_data_b = rd_data_b_p1;

    // Sweep FSM state and pointer registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // Sweep FSM next state: a clr pulse always restarts the sweep from entry 0.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            CLEAR: begin
                if (bus.clr) begin
                    clr_ptr_d = '0;
                end else if (clr_ptr_q == LAST_ADDR) begin
                    state_d   = IDLE;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end
            IDLE: begin
                if (bus.clr) begin
                    state_d   = CLEAR;
                    clr_ptr_d = '0;
                end
            end
            default: begin
                state_d   = CLEAR;
                clr_ptr_d = '0;
            end
        endcase
    end

    // Storage array: sweep writes zero, otherwise accepted writes land here.
    always_ff @(posedge clk) begin
        if (clearing) begin
            mem[clr_ptr_q] <= '0;
        end else if (wr_acc) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Next read values for both ports, with write-first forwarding.
    always_comb begin
        rd_next_a = read_sel(bus.rd_addr_a, mem[bus.rd_addr_a], clearing,
                             wr_acc, bus.wr_addr, bus.wr_data);
        rd_next_b = read_sel(bus.rd_addr_b, mem[bus.rd_addr_b], clearing,
                             wr_acc, bus.wr_addr, bus.wr_data);
    end

    // Registered read outputs; a disabled port holds its last value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_a_p1 <= '0;
            rd_data_b_p1 <= '0;
        end else begin
            if (bus.rd_en_a) rd_data_a_p1 <= rd_next_a;
            if (bus.rd_en_b) rd_data_b_p1 <= rd_next_b;
        end
    end
endmodule

// File: tb/tb_register_file_2r1w.sv
// Bench for register_file_2r1w: two instances (ZERO_REG=0 and ZERO_REG=1)
// share one stimulus stream; a reference model per instance feeds a
// scoreboard queue that a negedge monitor drains and compares.
module tb_register_file_2r1w;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    register_file_2r1w_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) if0 ();
    register_file_2r1w_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) if1 ();

    assign if1.clr       = if0.clr;
    assign if1.wr_en     = if0.wr_en;
    assign if1.wr_addr   = if0.wr_addr;
    assign if1.wr_data   = if0.wr_data;
    assign if1.rd_en_a   = if0.rd_en_a;
    assign if1.rd_addr_a = if0.rd_addr_a;
    assign if1.rd_en_b   = if0.rd_en_b;
    assign if1.rd_addr_b = if0.rd_addr_b;

    register_file_2r1w #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(if0)
    );
    register_file_2r1w #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(if1)
    );

    typedef struct {
        logic [DATA_W-1:0] a0, b0, a1, b1;
        logic              busy0, busy1;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: per instance, the array contents, sweep cycles left
    // and the currently presented read values.
    logic [DATA_W-1:0] m_mem [2][DEPTH];
    int                m_left [2];
    logic [DATA_W-1:0] m_a [2];
    logic [DATA_W-1:0] m_b [2];

    // Inputs that were applied before the upcoming clock edge.
    logic              p_rst, p_clr, p_we, p_ea, p_eb;
    logic [ADDR_W-1:0] p_wa, p_aa, p_ab;
    logic [DATA_W-1:0] p_wd;

    function automatic logic [DATA_W-1:0] model_read(input int k, input bit busy,
                                                     input bit acc, input logic [ADDR_W-1:0] addr);
        if (busy) return '0;
        if (k == 1 && addr == 0) return '0;
        if (acc && p_wa == addr) return p_wd;
        return m_mem[k][addr];
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            bit busy, acc;
            if (!p_rst) continue;
            busy = (m_left[k] > 0);
            acc  = !busy && p_we && !p_clr && !(k == 1 && p_wa == 0);
            if (p_ea) m_a[k] = model_read(k, busy, acc, p_aa);
            if (p_eb) m_b[k] = model_read(k, busy, acc, p_ab);
            if (p_clr) begin
                m_left[k] = DEPTH;
            end else if (busy) begin
                m_left[k]--;
                if (m_left[k] == 0)
                    for (int i = 0; i < DEPTH; i++) m_mem[k][i] = '0;
            end
            if (acc) m_mem[k][p_wa] = p_wd;
        end
    endtask

    // One clock cycle: account for the edge just taken, apply new inputs,
    // queue what the DUTs must present until the next edge.
    task automatic cyc(input logic r, input logic c, input logic we,
                       input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                       input logic ea, input logic [ADDR_W-1:0] aa,
                       input logic eb, input logic [ADDR_W-1:0] ab);
        exp_t e;
        @(posedge clk);
        #1;
        model_edge();
        reset_n       = r;
        if0.clr       = c;
        if0.wr_en     = we;
        if0.wr_addr   = wa;
        if0.wr_data   = wd;
        if0.rd_en_a   = ea;
        if0.rd_addr_a = aa;
        if0.rd_en_b   = eb;
        if0.rd_addr_b = ab;
        p_rst = r; p_clr = c; p_we = we; p_wa = wa; p_wd = wd;
        p_ea = ea; p_aa = aa; p_eb = eb; p_ab = ab;
        if (!r) begin
            for (int k = 0; k < 2; k++) begin
                m_left[k] = DEPTH;
                m_a[k]    = '0;
                m_b[k]    = '0;
            end
        end
        e.a0 = m_a[0]; e.b0 = m_b[0]; e.busy0 = (m_left[0] > 0);
        e.a1 = m_a[1]; e.b1 = m_b[1]; e.busy1 = (m_left[1] > 0);
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, '0, '0, 0, '0, 0, '0);
    endtask

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: outputs are stable at the falling edge; compare against the
    // oldest queued expectation.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("rd_data_a zr0", if0.rd_data_a, e.a0);
            check("rd_data_b zr0", if0.rd_data_b, e.b0);
            check("busy zr0", {7'd0, if0.busy}, {7'd0, e.busy0});
            check("rd_data_a zr1", if1.rd_data_a, e.a1);
            check("rd_data_b zr1", if1.rd_data_b, e.b1);
            check("busy zr1", {7'd0, if1.busy}, {7'd0, e.busy1});
        end
    end

    initial begin
        reset_n = 1'b0;
        if0.clr = 0; if0.wr_en = 0; if0.wr_addr = '0; if0.wr_data = '0;
        if0.rd_en_a = 0; if0.rd_addr_a = '0; if0.rd_en_b = 0; if0.rd_addr_b = '0;
        p_rst = 0; p_clr = 0; p_we = 0; p_wa = '0; p_wd = '0;
        p_ea = 0; p_aa = '0; p_eb = 0; p_ab = '0;
        for (int k = 0; k < 2; k++) begin
            m_left[k] = DEPTH;
            m_a[k] = '0;
            m_b[k] = '0;
            for (int i = 0; i < DEPTH; i++) m_mem[k][i] = '0;
        end

        // Reset, release, full sweep, then read every entry.
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, '0, '0, 0, '0, 0, '0);
        idle(17);
        for (int i = 0; i < DEPTH; i++)
            cyc(1, 0, 0, '0, '0, 1, ADDR_W'(i), 1, ADDR_W'(DEPTH - 1 - i));

        // Write then read back, then hold with read disabled.
        cyc(1, 0, 1, 4'd3, 8'hA5, 0, '0, 0, '0);
        cyc(1, 0, 0, '0, '0, 1, 4'd3, 0, '0);
        idle(3);

        // Same-cycle write and dual read of one address.
        cyc(1, 0, 1, 4'd7, 8'h3C, 1, 4'd7, 1, 4'd7);
        idle(2);

        // Fill, then clr together with a write that must be dropped.
        for (int i = 0; i < DEPTH; i++)
            cyc(1, 0, 1, ADDR_W'(i), DATA_W'(8'h11 * i + 1), 0, '0, 0, '0);
        cyc(1, 1, 1, 4'd2, 8'hFF, 0, '0, 0, '0);
        for (int i = 0; i < DEPTH; i++)
            cyc(1, 0, 1, ADDR_W'(i), 8'h77, 1, ADDR_W'(i), 1, 4'd2);
        for (int i = 0; i < DEPTH; i++)
            cyc(1, 0, 0, '0, '0, 1, ADDR_W'(i), 1, 4'd2);

        // Entry 0 write with forwarding read on both ports.
        cyc(1, 0, 1, 4'd0, 8'h55, 1, 4'd0, 1, 4'd0);
        cyc(1, 0, 0, '0, '0, 1, 4'd0, 1, 4'd0);

        // Reset in the middle of a sweep, then a full sweep again.
        cyc(1, 0, 1, 4'd9, 8'h9E, 1, 4'd9, 1, 4'd9);
        cyc(1, 1, 0, '0, '0, 0, '0, 0, '0);
        idle(5);
        cyc(0, 0, 0, '0, '0, 1, 4'd9, 1, 4'd9);
        cyc(0, 0, 0, '0, '0, 0, '0, 0, '0);
        idle(18);

        // Randomized traffic with occasional clr and rare resets.
        for (int n = 0; n < 3000; n++) begin
            logic [ADDR_W-1:0] wa, aa, ab;
            wa = ADDR_W'($urandom_range(0, DEPTH - 1));
            aa = ($urandom_range(0, 3) == 0) ? wa : ADDR_W'($urandom_range(0, DEPTH - 1));
            ab = ($urandom_range(0, 3) == 0) ? aa : ADDR_W'($urandom_range(0, DEPTH - 1));
            cyc(($urandom_range(0, 399) != 0), ($urandom_range(0, 79) == 0),
                1'($urandom_range(0, 1)), wa, DATA_W'($urandom),
                ($urandom_range(0, 3) != 0), aa, ($urandom_range(0, 3) != 0), ab);
        end
        idle(2);

        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard drain: %0d left, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
